// File: rtl/cv_rd_bus_mux.sv
// ---------------------------------------------------------------------------
// cv_rd_bus_mux
//
// Registered CPU read-data multiplexer for the Colecovision core. N chip-
// enabled read sources are merged onto the Z80 data-in bus with active-low
// wired-AND semantics. Each source can insert wait states. The last captured
// value is held between reads (open bus). Multi-source contention can
// optionally be detected and counted.
//
// Optional feature macro: CV_RD_BUS_MUX_CONTENTION_EN
//   defined   -> contention pulse and saturating 8-bit counter are built
//   undefined -> contention_o / contention_cnt_o are tied to 0
//
// Ports
//   clk_i             in   1          system clock
//   reset_i           in   1          synchronous active-high reset
//   rd_n_i            in   1          CPU read strobe, active low
//   src_ce_n_i        in   N_SRC      per-source read enable, active low
//   src_d_i           in   N_SRC*DW   source data, source i at [i*DW +: DW]
//   d_o               out  DW         registered read data
//   d_vld_o           out  1          high while d_o holds data for this read
//   wait_n_o          out  1          CPU wait request, active low
//   contention_o      out  1          one-cycle pulse after a contended capture
//   contention_cnt_o  out  8          saturating contention event counter
//   state_o           out  2          FSM state (debug)
//
// Read handshake: the CPU holds rd_n_i low for the whole read. A read is
// detected in IDLE, optionally stalled with wait_n_o low, then captured;
// d_vld_o stays high from the cycle after capture until rd_n_i returns high.
// rd_n_i rising before capture aborts the read with no capture. A new read
// needs at least one cycle with rd_n_i high after the previous one.
// ---------------------------------------------------------------------------
module cv_rd_bus_mux #(
    parameter int                        N_SRC    = 6,
    parameter int                        DW       = 8,
    parameter logic [DW-1:0]             INACT    = {DW{1'b1}},
    parameter int                        WAIT_W   = 2,
    parameter logic [N_SRC*WAIT_W-1:0]   SRC_WAIT = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rd_n_i,
    input  logic [N_SRC-1:0]      src_ce_n_i,
    input  logic [N_SRC*DW-1:0]   src_d_i,
    output logic [DW-1:0]         d_o,
    output logic                  d_vld_o,
    output logic                  wait_n_o,
    output logic                  contention_o,
    output logic [7:0]            contention_cnt_o,
    output logic [1:0]            state_o
);

    // Encoding chosen so that WAIT and HOLD each own one flop bit; the
    // wait/valid outputs are then direct flop outputs.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

    logic [1:0]        state;
    logic [WAIT_W-1:0] cnt;
    logic [DW-1:0]     merged;
    logic [WAIT_W-1:0] wait_tgt;
    logic              capture;

    // Wired-AND merge and wait target (max wait over enabled sources).
    always_comb begin
        merged   = {DW{1'b1}};
        wait_tgt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            merged = merged & (src_ce_n_i[i] ? INACT : src_d_i[i*DW +: DW]);
            if (!src_ce_n_i[i] && (SRC_WAIT[i*WAIT_W +: WAIT_W] > wait_tgt)) begin
                wait_tgt = SRC_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
    end

    assign capture = !rd_n_i &&
                     (((state == ST_IDLE) && (wait_tgt == '0)) ||
                      ((state == ST_WAIT) && (cnt == CNT_ONE)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            d_o   <= INACT;
        end else begin
            // d_o is only ever overwritten by a capture: open-bus hold.
            if (capture) begin
                d_o <= merged;
            end
            case (state)
                ST_IDLE: begin
                    if (!rd_n_i) begin
                        if (wait_tgt == '0) begin
                            state <= ST_HOLD;
                        end else begin
                            cnt   <= wait_tgt;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rd_n_i) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (rd_n_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign d_vld_o  = state[1];
    assign wait_n_o = ~state[0];
    assign state_o  = state;

`ifdef CV_RD_BUS_MUX_CONTENTION_EN
    logic [4:0] n_en;
    logic       multi;

    always_comb begin
        n_en = '0;
        for (int i = 0; i < N_SRC; i++) begin
            n_en = n_en + {4'b0, ~src_ce_n_i[i]};
        end
    end

    assign multi = (n_en > 5'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            contention_o     <= 1'b0;
            contention_cnt_o <= '0;
        end else begin
            contention_o <= capture && multi;
            if (capture && multi && (contention_cnt_o != 8'hFF)) begin
                contention_cnt_o <= contention_cnt_o + 8'd1;
            end
        end
    end
`else
    assign contention_o     = 1'b0;
    assign contention_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv_rd_bus_mux.sv
module tb_cv_rd_bus_mux;

    localparam int          N_SRC    = 6;
    localparam int          DW       = 8;
    localparam int          WAIT_W   = 2;
    // source 1 waits 1 cycle, source 2 waits 3 cycles, all others 0
    localparam logic [11:0] SRC_WAIT = 12'h034;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    logic        clk_i;
    logic        reset_i;
    logic        rd_n_i;
    logic [5:0]  src_ce_n_i;
    logic [47:0] src_d_i;
    logic [7:0]  d_o;
    logic        d_vld_o;
    logic        wait_n_o;
    logic        contention_o;
    logic [7:0]  contention_cnt_o;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    logic [7:0] exp_q[$];

    cv_rd_bus_mux #(
        .N_SRC(N_SRC), .DW(DW), .INACT(8'hFF), .WAIT_W(WAIT_W), .SRC_WAIT(SRC_WAIT)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .rd_n_i(rd_n_i),
        .src_ce_n_i(src_ce_n_i), .src_d_i(src_d_i),
        .d_o(d_o), .d_vld_o(d_vld_o), .wait_n_o(wait_n_o),
        .contention_o(contention_o), .contention_cnt_o(contention_cnt_o),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_merge(input logic [5:0] ce, input logic [47:0] d);
        logic [7:0] r = 8'hFF;
        for (int i = 0; i < N_SRC; i++) begin
            if (!ce[i]) r = r & d[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic int model_wait(input logic [5:0] ce);
        int w = 0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!ce[i] && int'(SRC_WAIT[i*2 +: 2]) > w) w = int'(SRC_WAIT[i*2 +: 2]);
        end
        return w;
    endfunction

    function automatic int model_pop(input logic [5:0] ce);
        int n = 0;
        for (int i = 0; i < N_SRC; i++) if (!ce[i]) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_d"},     d_o, 8'hFF);
        check_eq({tag, "_vld"},   d_vld_o, 1'b0);
        check_eq({tag, "_wait"},  wait_n_o, 1'b1);
        check_eq({tag, "_cpul"},  contention_o, 1'b0);
        check_eq({tag, "_ccnt"},  contention_cnt_o, 8'd0);
        check_eq({tag, "_state"}, state_o, ST_IDLE);
    endtask

    // ---------------- driver ----------------
    // Drives one read. d1 replaces d0 after the detection edge, so for a
    // waited read the captured value must come from d1.
    task automatic do_read(input logic [5:0] ce, input logic [47:0] d0, input logic [47:0] d1,
                           input int hold, input bit release_rd);
        int w, edges, waits;
        logic [7:0] exp_d, held;
        bit multi;
        w     = model_wait(ce);
        multi = (model_pop(ce) > 1);
        exp_d = model_merge(ce, (w > 0) ? d1 : d0);
        rd_n_i     = 1'b0;
        src_ce_n_i = ce;
        src_d_i    = d0;
        exp_q.push_back(exp_d);
        edges = 0;
        waits = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            edges++;
            if (edges == 1 && w > 0) src_d_i = d1;
            if (!wait_n_o) waits++;
            if (d_vld_o) break;
        end
        check_eq("vld_seen", d_vld_o, 1'b1);
        check_eq("latency", edges, w + 1);
        check_eq("wait_cycles", waits, w);
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            check_eq("rd_data", d_o, exp_q.pop_front());
        end
`ifdef CV_RD_BUS_MUX_CONTENTION_EN
        if (multi && exp_cnt < 255) exp_cnt++;
        check_eq("cont_pulse", contention_o, multi);
`else
        check_eq("cont_pulse", contention_o, 1'b0);
`endif
        check_eq("cont_cnt", contention_cnt_o, exp_cnt);
        held = d_o;
        for (int h = 0; h < hold; h++) begin
            tick();
            check_eq("hold_vld", d_vld_o, 1'b1);
            check_eq("hold_d", d_o, held);
            check_eq("hold_pulse_end", contention_o, 1'b0);
        end
        if (release_rd) begin
            rd_n_i     = 1'b1;
            src_ce_n_i = 6'h3F;
            src_d_i    = {$urandom, 16'(($urandom_range(0, 65535)))};
            tick();
            check_eq("rel_vld", d_vld_o, 1'b0);
            check_eq("open_bus", d_o, held);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] prev;
        logic [47:0] rd0, rd1;
        reset_i    = 1'b1;
        rd_n_i     = 1'b1;
        src_ce_n_i = 6'h3F;
        src_d_i    = '0;
        repeat (3) tick();
        reset_i = 1'b0;
        repeat (5) tick();
        check_reset_vals("rst_idle");

        // single source, no wait, held 3 cycles
        rd0 = 48'h1122_3344_553C;
        do_read(6'b111110, rd0, rd0, 2, 1'b1);
        check_eq("open_bus_3c", d_o, 8'h3C);

        // source 2 with three wait states
        rd0 = 48'h0000_00A5_0000;
        do_read(6'b111011, rd0, rd0, 1, 1'b1);

        // source 1 (1 wait) with data change after detection
        do_read(6'b111101, 48'h0000_0000_5500, 48'h0000_0000_6600, 0, 1'b1);

        // sources 0 and 4 wired-AND
        rd0 = 48'h003F_0000_00F0;
        do_read(6'b101110, rd0, rd0, 1, 1'b1);
        check_eq("merge_30", d_o, 8'h30);

        // sources 1 and 2 -> max wait 3
        do_read(6'b111001, 48'h0000_00F7_7F00, 48'h0000_00EE_7700, 0, 1'b1);

        // abort during WAIT: no capture, count unchanged
        prev       = d_o;
        rd_n_i     = 1'b0;
        src_ce_n_i = 6'b111010;
        src_d_i    = 48'h0;
        tick();
        check_eq("abort_wait0", wait_n_o, 1'b0);
        tick();
        check_eq("abort_wait1", wait_n_o, 1'b0);
        rd_n_i = 1'b1;
        tick();
        check_eq("abort_waitn", wait_n_o, 1'b1);
        check_eq("abort_vld", d_vld_o, 1'b0);
        check_eq("abort_d", d_o, prev);
        check_eq("abort_state", state_o, ST_IDLE);
        tick();
        check_eq("abort_pulse", contention_o, 1'b0);
        check_eq("abort_cnt", contention_cnt_o, exp_cnt);
        check_eq("abort_vld2", d_vld_o, 1'b0);

        // reset during WAIT
        rd_n_i     = 1'b0;
        src_ce_n_i = 6'b111010;
        tick();
        check_eq("rstw_state", state_o, ST_WAIT);
        reset_i = 1'b1;
        tick();
        exp_cnt = 0;
        check_reset_vals("rst_wait");
        reset_i = 1'b0;
        rd_n_i  = 1'b1;
        tick();

        // reset during HOLD (after a contended capture)
        do_read(6'b101110, 48'h0012_0000_0034, 48'h0012_0000_0034, 0, 1'b0);
        check_eq("rsth_state", state_o, ST_HOLD);
        reset_i = 1'b1;
        tick();
        exp_cnt = 0;
        check_reset_vals("rst_hold");
        reset_i = 1'b0;
        rd_n_i  = 1'b1;
        tick();

        // reset coinciding with a capture discards it
        rd_n_i     = 1'b0;
        src_ce_n_i = 6'b101110;
        src_d_i    = 48'h0;
        reset_i    = 1'b1;
        tick();
        check_reset_vals("rst_cap");
        reset_i = 1'b0;
        rd_n_i  = 1'b1;
        tick();

        // random reads
        for (int r = 0; r < 24; r++) begin
            rd0 = {$urandom, 16'($urandom_range(0, 65535))};
            rd1 = {$urandom, 16'($urandom_range(0, 65535))};
            do_read(6'($urandom_range(0, 63)), rd0, rd1, $urandom_range(0, 2), 1'b1);
        end

        // contention saturation
        exp_cnt = contention_cnt_o === 8'hxx ? 0 : exp_cnt;
        for (int r = 0; r < 300; r++) begin
            rd0 = 48'h003F_0000_00F0;
            do_read(6'b101110, rd0, rd0, 0, 1'b1);
        end
`ifdef CV_RD_BUS_MUX_CONTENTION_EN
        check_eq("cnt_sat", contention_cnt_o, 8'hFF);
`else
        check_eq("cnt_tied", contention_cnt_o, 8'h00);
`endif
        check_eq("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
